// File: rtl/ring_sequencer.sv
// Alarm ring cadence controller: gates the ring tone into beeps, spaces and
// group pauses, with stop, snooze and automatic session timeout.
module ring_sequencer #(
  parameter int unsigned TICK_DIV       = 1000000,
  parameter int unsigned ON_TICKS       = 25,
  parameter int unsigned OFF_TICKS      = 25,
  parameter int unsigned BURSTS         = 4,
  parameter int unsigned GAP_TICKS      = 100,
  parameter int unsigned TIMEOUT_GROUPS = 60,
  parameter int unsigned SNOOZE_TICKS   = 30000,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       alarm_match,
  input  logic       stop,
  input  logic       snooze,
  input  logic       ring_clk,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [1:0] snooze_cnt
);

  localparam int unsigned MAX_AB = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MAX_CD = (GAP_TICKS > SNOOZE_TICKS) ? GAP_TICKS : SNOOZE_TICKS;
  localparam int unsigned MAXT   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned PW     = $clog2(TICK_DIV);
  localparam int unsigned HW     = $clog2(MAXT + 1);
  localparam int unsigned BW     = $clog2(BURSTS + 1);
  localparam int unsigned GW     = $clog2(TIMEOUT_GROUPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEEP,
    S_SPACE,
    S_GAP,
    S_SNOOZE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [GW-1:0]   group_q, group_d;
  logic [1:0]      snz_cnt_q, snz_cnt_d;
  logic            am_q, stop_q, snz_q, primed_q;
  logic            buzzer_q;

  logic            tick, cad_done, am_edge, stop_edge, snz_edge, active;
  logic [HW-1:0]   phase_lim;
  logic [GW-1:0]   group_inc;

  // primed_q masks edges on the first cycle after reset, so an input that was
  // already high while reset was asserted is not mistaken for a fresh press.
  assign am_edge   = alarm_match & ~am_q & primed_q;
  assign stop_edge = stop & ~stop_q & primed_q;
  assign snz_edge  = snooze & ~snz_q & primed_q;

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign active    = (state_q == S_BEEP) || (state_q == S_SPACE) || (state_q == S_GAP);
  assign group_inc = group_q + GW'(1);

  always_comb begin
    phase_lim = '0;
    case (state_q)
      S_BEEP:   phase_lim = HW'(ON_TICKS - 1);
      S_SPACE:  phase_lim = HW'(OFF_TICKS - 1);
      S_GAP:    phase_lim = HW'(GAP_TICKS - 1);
      S_SNOOZE: phase_lim = HW'(SNOOZE_TICKS - 1);
      default:  phase_lim = '0;
    endcase
  end

  assign cad_done = tick && (phase_q == phase_lim);

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    phase_d   = tick ? phase_q + HW'(1) : phase_q;
    burst_d   = burst_q;
    group_d   = group_q;
    snz_cnt_d = snz_cnt_q;

    if (!enable) begin
      state_d   = S_IDLE;
      snz_cnt_d = '0;
    end else if (stop_edge && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else if (snz_edge && active && (32'(snz_cnt_q) < MAX_SNOOZE)) begin
      state_d   = S_SNOOZE;
      snz_cnt_d = snz_cnt_q + 2'd1;
      presc_d   = '0;
    end else if (am_edge && (state_q == S_IDLE)) begin
      state_d   = S_BEEP;
      burst_d   = '0;
      group_d   = '0;
      snz_cnt_d = '0;
      presc_d   = '0;
    end else if (cad_done) begin
      case (state_q)
        S_BEEP: begin
          if (burst_q == BW'(BURSTS - 1)) begin
            group_d = group_inc;
            state_d = (group_inc == GW'(TIMEOUT_GROUPS)) ? S_IDLE : S_GAP;
          end else begin
            burst_d = burst_q + BW'(1);
            state_d = S_SPACE;
          end
        end
        S_SPACE: state_d = S_BEEP;
        S_GAP: begin
          state_d = S_BEEP;
          burst_d = '0;
        end
        S_SNOOZE: begin
          state_d = S_BEEP;
          burst_d = '0;
          group_d = '0;
          presc_d = '0;
        end
        default: state_d = state_q;
      endcase
    end

    if (state_d != state_q) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      phase_q   <= '0;
      burst_q   <= '0;
      group_q   <= '0;
      snz_cnt_q <= '0;
      am_q      <= 1'b0;
      stop_q    <= 1'b0;
      snz_q     <= 1'b0;
      primed_q  <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      burst_q   <= burst_d;
      group_q   <= group_d;
      snz_cnt_q <= snz_cnt_d;
      am_q      <= alarm_match;
      stop_q    <= stop;
      snz_q     <= snooze;
      primed_q  <= 1'b1;
      buzzer_q  <= (state_d == S_BEEP) ? ring_clk : 1'b0;
    end
  end

  assign buzzer     = buzzer_q;
  assign ringing    = active;
  assign snoozed    = (state_q == S_SNOOZE);
  assign snooze_cnt = snz_cnt_q;

endmodule

// File: tb/tb_ring_sequencer.sv
// Directed bench for ring_sequencer with small cadence parameters; expected
// cadence per cycle is hand-derived (8 beep / 4 space / 12 gap cycles).
module tb_ring_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       alarm_match;
  logic       stop;
  logic       snooze;
  logic       ring_clk = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozed;
  logic [1:0] snooze_cnt;

  int checks   = 0;
  int failures = 0;

  ring_sequencer #(
    .TICK_DIV      (4),
    .ON_TICKS      (2),
    .OFF_TICKS     (1),
    .BURSTS        (2),
    .GAP_TICKS     (3),
    .TIMEOUT_GROUPS(2),
    .SNOOZE_TICKS  (5),
    .MAX_SNOOZE    (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .alarm_match(alarm_match),
    .stop       (stop),
    .snooze     (snooze),
    .ring_clk   (ring_clk),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozed    (snoozed),
    .snooze_cnt (snooze_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ring_clk <= ~ring_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Session cycle c counts from the edge that sampled the alarm rise.
  function automatic logic in_beep(input int c);
    return (c < 8) || (c >= 12 && c < 20) || (c >= 32 && c < 40) || (c >= 44 && c < 52);
  endfunction

  task automatic check_cycle(input string tag, input int c);
    logic eb;
    eb = in_beep(c) ? ~ring_clk : 1'b0;
    check({tag, "_ringing"}, ringing, (c < 52) ? 1 : 0);
    check({tag, "_buzzer"}, buzzer, eb);
    check({tag, "_snoozed"}, snoozed, 0);
  endtask

  task automatic seg(input string tag, input int a, input int b);
    for (int c = a; c <= b; c++) begin
      check_cycle(tag, c);
      step();
    end
  endtask

  task automatic start();
    alarm_match = 1'b1;
    step();
    alarm_match = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b1;
    alarm_match = 1'b0;
    stop        = 1'b0;
    snooze      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_buzzer", buzzer, 0);
    check("rst_ringing", ringing, 0);
    check("rst_snoozed", snoozed, 0);
    check("rst_snzcnt", snooze_cnt, 0);
    reset_n = 1'b1;
    step();
    step();
    check("idle_ringing", ringing, 0);

    // Full uninterrupted session.
    start();
    seg("full", 0, 52);

    // Stop during first SPACE, then a fresh session from group 0.
    start();
    seg("stop_pre", 0, 9);
    check_cycle("stop_pre", 10);
    stop = 1'b1;
    step();
    check("stop_ringing", ringing, 0);
    check("stop_buzzer", buzzer, 0);
    repeat (3) begin
      step();
      check("stop_held", ringing, 0);
    end
    stop = 1'b0;
    step();
    start();
    seg("restart", 0, 52);

    // Snooze in first SPACE, then a full fresh session with an ignored snooze.
    start();
    seg("snz_pre", 0, 8);
    check_cycle("snz_pre", 9);
    snooze = 1'b1;
    step();
    for (int s = 0; s < 20; s++) begin
      check("snz_snoozed", snoozed, 1);
      check("snz_ringing", ringing, 0);
      check("snz_buzzer", buzzer, 0);
      check("snz_cnt", snooze_cnt, 1);
      if (s == 1) snooze = 1'b0;
      step();
    end
    seg("snz_post", 0, 8);
    snooze = 1'b1;
    seg("snz_ign", 9, 11);
    snooze = 1'b0;
    seg("snz_tail", 12, 52);
    check("snz_cnt_end", snooze_cnt, 1);

    // Stop and snooze together: stop wins, snooze count untouched.
    start();
    check("prio_cnt0", snooze_cnt, 0);
    seg("prio_pre", 0, 4);
    stop   = 1'b1;
    snooze = 1'b1;
    step();
    check("prio_ringing", ringing, 0);
    check("prio_snoozed", snoozed, 0);
    check("prio_cnt", snooze_cnt, 0);
    stop   = 1'b0;
    snooze = 1'b0;
    step();

    // Dropping enable while snoozed clears the snooze count.
    start();
    seg("en_pre", 0, 2);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check("en_snoozed", snoozed, 1);
    check("en_cnt1", snooze_cnt, 1);
    step();
    enable = 1'b0;
    step();
    check("en_snoozed0", snoozed, 0);
    check("en_ringing0", ringing, 0);
    check("en_cnt0", snooze_cnt, 0);
    enable = 1'b1;
    step();

    // Asynchronous reset mid-BEEP with alarm_match held high through it.
    start();
    seg("ar_pre", 0, 3);
    #2;
    alarm_match = 1'b1;
    reset_n     = 1'b0;
    #1;
    check("ar_ringing", ringing, 0);
    check("ar_buzzer", buzzer, 0);
    check("ar_snzcnt", snooze_cnt, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      step();
      check("ar_held", ringing, 0);
    end
    alarm_match = 1'b0;
    step();
    start();
    seg("ar_after", 0, 52);

    // Alarm edge during GAP must not disturb the cadence.
    start();
    seg("rt_pre", 0, 23);
    alarm_match = 1'b1;
    seg("rt_gap", 24, 25);
    alarm_match = 1'b0;
    seg("rt_tail", 26, 52);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_sequencer.md
# ring_sequencer

Alarm ring controller that sequences the buzzer tone. It gates the square-wave ring tone (produced by the ring clock divider) into a timed cadence of beeps, spaces and pauses between beep groups. It also handles dismiss (stop), snooze and automatic timeout. It sits between the alarm time-compare logic / debounced pushbuttons and the buzzer output pin.

## Interface
Parameters:
- TICK_DIV, 1000000: clk cycles per cadence tick (10 ms at 100 MHz); must be ≥ 2.
- ON_TICKS, 25: beep length in ticks (≥ 1).
- OFF_TICKS, 25: space between beeps inside a group, in ticks (≥ 1).
- BURSTS, 4: beeps per group (≥ 1).
- GAP_TICKS, 100: pause after a group, in ticks (≥ 1).
- TIMEOUT_GROUPS, 60: groups per ring session before auto-stop (≥ 1).
- SNOOZE_TICKS, 30000: snooze length in ticks (≥ 1).
- MAX_SNOOZE, 3: snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  alarm armed; low forces IDLE.
- alarm_match  in  1  level from the time comparator; a rising edge starts a ring session.
- stop  in  1  debounced dismiss button; acts on the rising edge.
- snooze  in  1  debounced snooze button; acts on the rising edge.
- ring_clk  in  1  tone square wave, synchronous to clk.
- buzzer  out  1  gated tone to the buzzer, registered.
- ringing  out  1  high in BEEP, SPACE or GAP.
- snoozed  out  1  high in SNOOZE.
- snooze_cnt  out  2  snoozes used in the current event.

## Operation
- States: IDLE, BEEP, SPACE, GAP, SNOOZE.
- Edge detectors: registered copies of alarm_match, stop and snooze. edge = input & ~previous. All three registers reset to 0.
- Tick prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick when it wraps. It is cleared to 0 on every transition into BEEP from IDLE or SNOOZE, and on entry to SNOOZE.
- Phase counter: counts ticks in the current state; it is cleared on every state change. burst_cnt counts beeps in the current group; group_cnt counts completed groups.
- IDLE → BEEP on alarm edge while enable=1. This clears burst_cnt, group_cnt, snooze_cnt and the prescaler.
- BEEP → SPACE after ON_TICKS ticks, if it was not the last beep of the group.
- On the last beep: group_cnt increments. Next state is IDLE if the new group_cnt equals TIMEOUT_GROUPS, otherwise GAP.
- SPACE → BEEP after OFF_TICKS ticks. GAP → BEEP after GAP_TICKS ticks, with burst_cnt cleared.
- stop edge in BEEP, SPACE, GAP or SNOOZE → IDLE.
- snooze edge in BEEP, SPACE or GAP:
  - if snooze_cnt < MAX_SNOOZE: go to SNOOZE and increment snooze_cnt;
  - otherwise the edge is ignored.
- SNOOZE → BEEP after SNOOZE_TICKS ticks. burst_cnt and group_cnt are cleared; snooze_cnt is kept.
- Priority on the same cycle: enable=0 > stop > snooze > alarm edge > cadence timeout.
- An alarm edge outside IDLE is ignored.
- enable=0 in any state → IDLE on the next edge, and snooze_cnt is cleared.
- buzzer <= ring_clk when the next state is BEEP, else 0.
- ringing and snoozed are decoded from the registered state.
- Counters: the prescaler is sized to hold TICK_DIV-1 and the phase counter to hold the maximum tick parameter. No counter may wrap within a state.

## Timing
- Reset values: state=IDLE, buzzer=0, ringing=0, snoozed=0, snooze_cnt=0, all counters 0.
- Reset asserted mid-ring: outputs reach their reset values immediately (asynchronously).
- Start latency: alarm_match is first sampled high at edge N. Then state=BEEP and ringing=1 after edge N. buzzer follows ring_clk from edge N onward, with one cycle of delay.
- Beep length: BEEP lasts exactly ON_TICKS·TICK_DIV cycles, SPACE OFF_TICKS·TICK_DIV, GAP GAP_TICKS·TICK_DIV and SNOOZE SNOOZE_TICKS·TICK_DIV.
- Session length without interaction: TIMEOUT_GROUPS·(BURSTS·ON + (BURSTS-1)·OFF)·TICK_DIV + (TIMEOUT_GROUPS-1)·GAP_TICKS·TICK_DIV cycles.
- stop or snooze takes effect at the edge where its rising edge is sampled; buzzer is 0 from the following cycle.
- A button held high produces one action only.

## Test plan
Bench parameters: TICK_DIV=4, ON=2, OFF=1, BURSTS=2, GAP=3, TIMEOUT_GROUPS=2, SNOOZE=5, MAX_SNOOZE=1. ring_clk toggles every cycle.
- Full session: alarm_match rise with enable=1 → BEEP 8 cycles, SPACE 4, BEEP 8, GAP 12, BEEP 8, SPACE 4, BEEP 8, then IDLE. ringing is high for exactly 52 cycles, and buzzer mirrors ring_clk (1-cycle lag) only during BEEP.
- Stop: stop edge at cycle 10 of the session → IDLE next edge. buzzer=0 and ringing=0. A second alarm edge restarts at group 0.
- Snooze: snooze edge in first SPACE → snoozed=1 for 20 cycles, snooze_cnt=1, then BEEP with a fresh group. A second snooze edge is ignored and ringing stays 1.
- Priority: stop and snooze edges in the same cycle → IDLE and snooze_cnt unchanged. enable dropped in SNOOZE → IDLE and snooze_cnt=0.
- Async reset mid-BEEP: reset_n low between clk edges → buzzer, ringing and state are cleared at once. After release, a held-high alarm_match does not retrigger until it goes low and then high again.
- Retrigger guard: a new alarm_match edge during GAP → ignored, and the cadence is unchanged.
